axi_rd_arbiter: RTL and testbench

Two-master, one-slave AXI-lite read-channel arbiter that shares the instruction/data SRAM between the IFU (master 0) and the LSU (master 1). It accepts one read request at a time, forwards it to the SRAM slave port, and routes the single response back to the granted master. Only one transaction is outstanding at a time. It sits between the core's fetch/load units and the SRAM and tolerates arbitrary slave handshake delays.

---
 rtl/axi_pkg.sv | 16 +
 rtl/arb_sel2.sv | 34 +++
 rtl/axi_rd_arbiter.sv | 148 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the two-master AXI-lite read arbiter.
package axi_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/arb_sel2.sv
// Two-requester grant selector: fixed priority (LSU over IFU) by default,
// two-way round-robin when AXI_RD_ARB_RR_EN is defined.
module arb_sel2
    import axi_pkg::*;
(
    input  logic [1:0] req,
`ifdef AXI_RD_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic       sel,
    output logic       any_req
);

    // Pick the winner among the active requests.
    always_comb begin
        any_req = |req;
`ifdef AXI_RD_ARB_RR_EN
        if (req == 2'b11) begin
            sel = ~last_grant;
        end else if (req[1]) begin
            sel = MST_LSU;
        end else begin
            sel = MST_IFU;
        end
`else
        if (req[1]) begin
            sel = MST_LSU;
        end else begin
            sel = MST_IFU;
        end
`endif
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI-lite read arbiter with a single outstanding
// transaction. Define AXI_RD_ARB_RR_EN for round-robin arbitration.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RESP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [RESP_W-1:0] m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [RESP_W-1:0] m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [RESP_W-1:0] s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready
);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sel_s, any_req_s, rready_s;
    logic [1:0]        arready_s;
`ifdef AXI_RD_ARB_RR_EN
    logic              last_grant_q, last_grant_d;
`endif

    arb_sel2 u_sel (
        .req        ({m1_arvalid, m0_arvalid}),
`ifdef AXI_RD_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .sel        (sel_s),
        .any_req    (any_req_s)
    );

    // Acceptance is masked during reset so nothing is granted before the first live edge.
    assign m0_arready = arready_s[0] & rst;
    assign m1_arready = arready_s[1] & rst;

    // Next-state, address capture and response routing.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
`ifdef AXI_RD_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        arready_s = 2'b00;
        rready_s  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = {ADDR_W{1'b0}};
        s_rready  = 1'b0;
        m0_rvalid = 1'b0;
        m0_rdata  = {DATA_W{1'b0}};
        m0_rresp  = {RESP_W{1'b0}};
        m1_rvalid = 1'b0;
        m1_rdata  = {DATA_W{1'b0}};
        m1_rresp  = {RESP_W{1'b0}};
        case (state_q)
            ARB_IDLE: begin
                if (any_req_s) begin
                    if (sel_s == MST_LSU) begin
                        arready_s = 2'b10;
                        addr_d    = m1_araddr;
                    end else begin
                        arready_s = 2'b01;
                        addr_d    = m0_araddr;
                    end
                    grant_d = sel_s;
`ifdef AXI_RD_ARB_RR_EN
                    last_grant_d = sel_s;
`endif
                    state_d = ARB_AR;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_AR: begin
                s_arvalid = 1'b1;
                s_araddr  = addr_q;
                if (s_arready) begin
                    state_d = ARB_R;
                end else begin
                    state_d = ARB_AR;
                end
            end
            ARB_R: begin
                if (grant_q == MST_LSU) begin
                    rready_s  = m1_rready;
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    rready_s  = m0_rready;
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
                s_rready = rready_s;
                if (s_rvalid && rready_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_R;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, grant and captured address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            grant_q <= MST_IFU;
            addr_q  <= {ADDR_W{1'b0}};
`ifdef AXI_RD_ARB_RR_EN
            last_grant_q <= MST_LSU;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
`ifdef AXI_RD_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: master agents, an SRAM responder with
// programmable delays, and expected transactions queued in grant order.
module tb_axi_rd_arbiter;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;

    typedef struct packed {
        logic        mst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mq0[$], mq1[$];
    int          n_checks = 0, n_fail = 0;
    int          ar_delay = 0, r_delay = 0, stall_cnt = 0, sl_phase = 0, sl_cnt = 0;
    logic        acc0 = 1'b0, acc1 = 1'b0;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RESP_W(2)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dgen(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic push_exp(input logic mst, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] r);
        exp_t e;
        e.mst = mst; e.addr = a; e.data = d; e.resp = r;
        sb.push_back(e);
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_arready"}, 64'({m1_arready, m0_arready}), 64'd0);
        check_val({tag, "_valid_ready"}, 64'({m0_rvalid, m1_rvalid, s_arvalid, s_rready}), 64'd0);
        check_val({tag, "_m0_r"}, 64'({m0_rresp, m0_rdata}), 64'd0);
        check_val({tag, "_m1_r"}, 64'({m1_rresp, m1_rdata}), 64'd0);
        check_val({tag, "_s_araddr"}, 64'(s_araddr), 64'd0);
    endtask

    task automatic check_beat();
        exp_t e;
        e = sb[0];
        if (e.mst) begin
            check_val("m1_rvalid", 64'(m1_rvalid), 64'd1);
            check_val("m1_rresp_rdata", 64'({m1_rresp, m1_rdata}), 64'({e.resp, e.data}));
            check_val("m0_idle_r", 64'({m0_rvalid, m0_rresp, m0_rdata}), 64'd0);
            check_val("s_rready_m1", 64'(s_rready), 64'(m1_rready));
        end else begin
            check_val("m0_rvalid", 64'(m0_rvalid), 64'd1);
            check_val("m0_rresp_rdata", 64'({m0_rresp, m0_rdata}), 64'({e.resp, e.data}));
            check_val("m1_idle_r", 64'({m1_rvalid, m1_rresp, m1_rdata}), 64'd0);
            check_val("s_rready_m0", 64'(s_rready), 64'(m0_rready));
        end
        if (s_rready) sl_phase = 5;
        else stall_cnt++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && mq0.size() == 0 && mq1.size() == 0) break;
            @(negedge clk);
        end
        check_val("drain", 64'(sb.size() + mq0.size() + mq1.size()), 64'd0);
        sb.delete(); mq0.delete(); mq1.delete();
        @(negedge clk);
    endtask

    // Master 0 agent: presents queued addresses, retires one per accepted handshake.
    initial begin : agent0
        m0_arvalid = 1'b0; m0_araddr = 32'd0;
        forever begin
            @(negedge clk);
            if (acc0 && mq0.size() > 0) void'(mq0.pop_front());
            acc0 = 1'b0;
            if (mq0.size() > 0) begin m0_arvalid = 1'b1; m0_araddr = mq0[0]; end
            else begin m0_arvalid = 1'b0; m0_araddr = 32'd0; end
            #1;
            acc0 = rst & m0_arready;
        end
    end

    // Master 1 agent.
    initial begin : agent1
        m1_arvalid = 1'b0; m1_araddr = 32'd0;
        forever begin
            @(negedge clk);
            if (acc1 && mq1.size() > 0) void'(mq1.pop_front());
            acc1 = 1'b0;
            if (mq1.size() > 0) begin m1_arvalid = 1'b1; m1_araddr = mq1[0]; end
            else begin m1_arvalid = 1'b0; m1_araddr = 32'd0; end
            #1;
            acc1 = rst & m1_arready;
        end
    end

    // SRAM responder: answers in scoreboard order, checks address and forwarded beat.
    initial begin : sram
        exp_t e;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'd0; s_rresp = 2'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'd0; s_rresp = 2'd0;
                sl_phase = 0;
            end else begin
                case (sl_phase)
                    0: if (s_arvalid) begin
                        if (sb.size() == 0) check_val("unexpected_ar", 64'(sb.size()), 64'd1);
                        else begin
                            check_val("s_araddr", 64'(s_araddr), 64'(sb[0].addr));
                            sl_cnt = ar_delay; sl_phase = 1;
                        end
                    end
                    1: begin
                        check_val("s_araddr_hold", 64'({s_arvalid, s_araddr}), 64'({1'b1, sb[0].addr}));
                        if (sl_cnt == 0) begin s_arready = 1'b1; sl_phase = 2; end
                        else sl_cnt--;
                    end
                    2: begin
                        s_arready = 1'b0;
                        check_val("s_arvalid_drop", 64'(s_arvalid), 64'd0);
                        sl_cnt = r_delay; sl_phase = 3;
                    end
                    3: if (sl_cnt == 0) begin
                        e = sb[0];
                        s_rvalid = 1'b1; s_rdata = e.data; s_rresp = e.resp;
                        stall_cnt = 0; sl_phase = 4;
                    end else sl_cnt--;
                    4: begin end
                    5: begin
                        s_rvalid = 1'b0; s_rdata = 32'd0; s_rresp = 2'd0;
                        void'(sb.pop_front());
                        sl_phase = 0;
                    end
                    default: sl_phase = 0;
                endcase
                if (sl_phase == 4) begin
                    #1;
                    check_beat();
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int sights;
        rst = 1'b0; m0_rready = 1'b1; m1_rready = 1'b1;

        // Reset held with both masters requesting.
`ifdef AXI_RD_ARB_RR_EN
        push_exp(1'b0, 32'h8000_0100, dgen(32'h8000_0100), RESP_OKAY);
        push_exp(1'b1, 32'h8000_0200, dgen(32'h8000_0200), RESP_OKAY);
`else
        push_exp(1'b1, 32'h8000_0200, dgen(32'h8000_0200), RESP_OKAY);
        push_exp(1'b0, 32'h8000_0100, dgen(32'h8000_0100), RESP_OKAY);
`endif
        mq0.push_back(32'h8000_0100); mq1.push_back(32'h8000_0200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check_reset_outs("rst_hold");
        end
        @(negedge clk); rst = 1'b1;
        wait_done();

        // Single IFU read with slave delays.
        ar_delay = 3; r_delay = 5;
        push_exp(1'b0, 32'h8000_0000, 32'h0000_0413, RESP_OKAY);
        mq0.push_back(32'h8000_0000);
        wait_done();

        // Simultaneous requests: LSU first in both policies given the preceding grant.
        ar_delay = 1; r_delay = 1;
        push_exp(1'b1, 32'h8000_1000, dgen(32'h8000_1000), RESP_OKAY);
        push_exp(1'b0, 32'h8000_0004, dgen(32'h8000_0004), RESP_OKAY);
        mq0.push_back(32'h8000_0004); mq1.push_back(32'h8000_1000);
        wait_done();

        // Fresh reset, then both masters held for four transactions.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        ar_delay = 0; r_delay = 0;
`ifdef AXI_RD_ARB_RR_EN
        push_exp(1'b0, 32'h8000_0010, dgen(32'h8000_0010), RESP_OKAY);
        push_exp(1'b1, 32'h8000_1010, dgen(32'h8000_1010), RESP_OKAY);
        push_exp(1'b0, 32'h8000_0014, dgen(32'h8000_0014), RESP_OKAY);
        push_exp(1'b1, 32'h8000_1014, dgen(32'h8000_1014), RESP_OKAY);
`else
        push_exp(1'b1, 32'h8000_1010, dgen(32'h8000_1010), RESP_OKAY);
        push_exp(1'b1, 32'h8000_1014, dgen(32'h8000_1014), RESP_OKAY);
        push_exp(1'b0, 32'h8000_0010, dgen(32'h8000_0010), RESP_OKAY);
        push_exp(1'b0, 32'h8000_0014, dgen(32'h8000_0014), RESP_OKAY);
`endif
        mq0.push_back(32'h8000_0010); mq0.push_back(32'h8000_0014);
        mq1.push_back(32'h8000_1010); mq1.push_back(32'h8000_1014);
        wait_done();

        // LSU backpressure for four cycles with an error response.
        ar_delay = 2; r_delay = 1; m1_rready = 1'b0; sights = 0;
        push_exp(1'b1, 32'h8000_2000, dgen(32'h8000_2000), RESP_SLVERR);
        mq1.push_back(32'h8000_2000);
        for (int i = 0; i < 200 && sights < 4; i++) begin
            @(negedge clk);
            if (s_rvalid) sights++;
        end
        m1_rready = 1'b1;
        check_val("rvalid_seen", 64'(sights), 64'd4);
        wait_done();
        check_val("stall_cycles", 64'(stall_cnt), 64'd4);
        check_val("state_idle_after_err", 64'(dut.state_q), 64'(ARB_IDLE));

        // Reset while a response is being presented to a stalled IFU.
        ar_delay = 0; r_delay = 2; m0_rready = 1'b0;
        push_exp(1'b0, 32'h8000_3000, dgen(32'h8000_3000), RESP_OKAY);
        mq0.push_back(32'h8000_3000);
        for (int i = 0; i < 200 && sl_phase != 4; i++) @(negedge clk);
        check_val("pre_reset_rvalid", 64'(m0_rvalid), 64'd1);
        #3; rst = 1'b0; #1;
        check_reset_outs("rst_mid");
        check_val("state_idle_on_reset", 64'(dut.state_q), 64'(ARB_IDLE));
        sb.delete(); mq0.delete(); mq1.delete();
        @(negedge clk); @(negedge clk); rst = 1'b1; m0_rready = 1'b1;
        push_exp(1'b0, 32'h8000_4000, dgen(32'h8000_4000), RESP_OKAY);
        mq0.push_back(32'h8000_4000);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
